// File: rtl/dram_tg_pkg.sv
// Shared definitions for the DRAM traffic generator: FSM encoding, LFSR polynomial,
// data-expansion constant and counter widths.
package dram_tg_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_WAIT_RDY  = 4'd1,
      ST_WR_REQ    = 4'd2,
      ST_WR_GAP    = 4'd3,
      ST_RD_SEED   = 4'd4,
      ST_WAIT_RDY2 = 4'd5,
      ST_RD_REQ    = 4'd6,
      ST_RD_GAP    = 4'd7,
      ST_DONE      = 4'd8
   } tg_state_t;

   // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [31:0] GOLDEN    = 32'h9E37_79B9;

   localparam int ERR_W  = 16;
   localparam int XFER_W = 16;
   localparam int TMO_W  = 32;

   function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
      return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0000_0000);
   endfunction

endpackage

// File: rtl/dram_tg_lfsr.sv
// 32-bit Galois LFSR with synchronous reload to the seed and single-step advance.
module dram_tg_lfsr
   import dram_tg_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   output logic [31:0] state
);

   logic [31:0] state_r;

   // LFSR state: reload has priority over stepping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= SEED;
      end else if (load) begin
         state_r <= SEED;
      end else if (step) begin
         state_r <= lfsr_next(state_r);
      end else begin
         state_r <= state_r;
      end
   end

   assign state = state_r;

endmodule

// File: rtl/dram_traffic_gen.sv
// Memory self-test requester: writes NUM_XFERS LFSR-derived bursts, reads them back,
// and reports pass/fail, mismatch count, first failing address and ack timeout.
module dram_traffic_gen
   import dram_tg_pkg::*;
#(
   parameter int                ADDR_W      = 27,
   parameter int                DATA_W      = 64,
   parameter int                NUM_XFERS   = 16,
   parameter logic [ADDR_W-1:0] ADDR_BASE   = {ADDR_W{1'b0}},
   parameter int                ADDR_STRIDE = 8,
   parameter logic [31:0]       SEED        = 32'hACE1_0001,
   parameter int                TIMEOUT     = 4096
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              busy_i,
   input  logic              ack_i,
   input  logic [DATA_W-1:0] read_data_i,
   output logic              read_o,
   output logic              write_o,
   output logic [ADDR_W-1:0] address_o,
   output logic [DATA_W-1:0] write_data_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [15:0]       err_cnt_o,
   output logic [ADDR_W-1:0] first_err_o,
   output logic              timeout_o
);

   localparam int                NWORDS    = DATA_W / 32;
   localparam logic [ADDR_W-1:0] STRIDE_C  = ADDR_W'(ADDR_STRIDE);
   localparam logic [XFER_W-1:0] LAST_XFER = XFER_W'(NUM_XFERS);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

   tg_state_t         state_r, state_s;
   logic              read_r, read_s, write_r, write_s;
   logic              done_r, done_s, pass_r, pass_s, tout_r, tout_s;
   logic [ADDR_W-1:0] addr_r, addr_s, ferr_r, ferr_s;
   logic [DATA_W-1:0] wdata_r, wdata_s;
   logic [ERR_W-1:0]  err_r, err_s;
   logic [XFER_W-1:0] xfer_r, xfer_s;
   logic [TMO_W-1:0]  tcnt_r, tcnt_s;
   logic              lfsr_load_s, lfsr_step_s;
   logic [31:0]       lfsr_s;
   logic [DATA_W-1:0] exp_data_s;

   dram_tg_lfsr #(.SEED(SEED)) u_lfsr (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .load  (lfsr_load_s),
      .step  (lfsr_step_s),
      .state (lfsr_s)
   );

   // Same expansion serves as write payload and as read-back expectation
   for (genvar j = 0; j < NWORDS; j++) begin : g_word
      assign exp_data_s[32*j +: 32] = lfsr_s ^ (GOLDEN * 32'(j));
   end

   // Next-state and next-output logic; a request is only raised after sampling busy_i low
   always_comb begin
      state_s     = state_r;
      read_s      = 1'b0;
      write_s     = 1'b0;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      done_s      = done_r;
      pass_s      = pass_r;
      tout_s      = tout_r;
      err_s       = err_r;
      ferr_s      = ferr_r;
      xfer_s      = xfer_r;
      tcnt_s      = tcnt_r;
      lfsr_load_s = 1'b0;
      lfsr_step_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_s     = ST_WAIT_RDY;
               done_s      = 1'b0;
               pass_s      = 1'b0;
               tout_s      = 1'b0;
               err_s       = {ERR_W{1'b0}};
               ferr_s      = {ADDR_W{1'b0}};
               xfer_s      = {XFER_W{1'b0}};
               addr_s      = ADDR_BASE;
               lfsr_load_s = 1'b1;
            end else begin
               state_s = state_r;
            end
         end
         ST_WAIT_RDY, ST_WR_GAP: begin
            if ((state_r == ST_WR_GAP) && (xfer_r == LAST_XFER)) begin
               state_s = ST_RD_SEED;
            end else if (!busy_i) begin
               state_s = ST_WR_REQ;
               write_s = 1'b1;
               wdata_s = exp_data_s;
               tcnt_s  = {TMO_W{1'b0}};
            end else begin
               state_s = state_r;
            end
         end
         ST_WR_REQ, ST_RD_REQ: begin
            write_s = (state_r == ST_WR_REQ);
            read_s  = (state_r == ST_RD_REQ);
            if (ack_i) begin
               write_s     = 1'b0;
               read_s      = 1'b0;
               lfsr_step_s = 1'b1;
               addr_s      = addr_r + STRIDE_C;
               xfer_s      = xfer_r + 16'd1;
               state_s     = (state_r == ST_WR_REQ) ? ST_WR_GAP : ST_RD_GAP;
               if ((state_r == ST_RD_REQ) && (read_data_i != exp_data_s)) begin
                  err_s  = (err_r == 16'hFFFF) ? err_r : err_r + 16'd1;
                  ferr_s = (err_r == {ERR_W{1'b0}}) ? addr_r : ferr_r;
               end else begin
                  err_s = err_r;
               end
            end else if (tcnt_r == TMO_LAST) begin
               write_s = 1'b0;
               read_s  = 1'b0;
               tout_s  = 1'b1;
               done_s  = 1'b1;
               pass_s  = 1'b0;
               state_s = ST_DONE;
            end else begin
               tcnt_s = tcnt_r + 32'd1;
            end
         end
         ST_RD_SEED: begin
            lfsr_load_s = 1'b1;
            addr_s      = ADDR_BASE;
            xfer_s      = {XFER_W{1'b0}};
            state_s     = ST_WAIT_RDY2;
         end
         ST_WAIT_RDY2, ST_RD_GAP: begin
            if ((state_r == ST_RD_GAP) && (xfer_r == LAST_XFER)) begin
               state_s = ST_DONE;
               done_s  = 1'b1;
               pass_s  = (err_r == {ERR_W{1'b0}}) && !tout_r;
            end else if (!busy_i) begin
               state_s = ST_RD_REQ;
               read_s  = 1'b1;
               tcnt_s  = {TMO_W{1'b0}};
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any request immediately
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
         read_r  <= 1'b0;
         write_r <= 1'b0;
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= {DATA_W{1'b0}};
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
         tout_r  <= 1'b0;
         err_r   <= {ERR_W{1'b0}};
         ferr_r  <= {ADDR_W{1'b0}};
         xfer_r  <= {XFER_W{1'b0}};
         tcnt_r  <= {TMO_W{1'b0}};
      end else begin
         state_r <= state_s;
         read_r  <= read_s;
         write_r <= write_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
         done_r  <= done_s;
         pass_r  <= pass_s;
         tout_r  <= tout_s;
         err_r   <= err_s;
         ferr_r  <= ferr_s;
         xfer_r  <= xfer_s;
         tcnt_r  <= tcnt_s;
      end
   end

   assign read_o       = read_r;
   assign write_o      = write_r;
   assign address_o    = addr_r;
   assign write_data_o = wdata_r;
   assign done_o       = done_r;
   assign pass_o       = pass_r;
   assign timeout_o    = tout_r;
   assign err_cnt_o    = err_r;
   assign first_err_o  = ferr_r;

endmodule

// File: tb/tb_dram_traffic_gen.sv
// Directed bench for dram_traffic_gen: a 3-cycle-ack memory responder on the main instance and a
// zero-wait responder on a second instance configured to wrap the address space.
module tb_dram_traffic_gen;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        start_i, busy_i, ack_i, ack2;
   logic [63:0] read_data_i, read_data2;
   logic        read_o, write_o, done_o, pass_o, timeout_o;
   logic        read2, write2, done2, pass2, timeout2;
   logic [26:0] address_o, first_err_o, address2, first_err2;
   logic [63:0] write_data_o, write_data2;
   logic [15:0] err_cnt_o, err_cnt2;

   int          n_checks = 0;
   int          n_errors = 0;
   bit          no_ack = 1'b0;
   bit          corrupt = 1'b0;
   int          both_high = 0;
   int          req_cyc = 0;
   logic [63:0] mem  [logic [26:0]];
   logic [63:0] mem2 [logic [26:0]];
   logic [26:0] wr_q[$], rd_q[$], wr2_q[$], rd2_q[$];

   always #5 clk_i = ~clk_i;

   dram_traffic_gen dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .busy_i(busy_i), .ack_i(ack_i),
      .read_data_i(read_data_i), .read_o(read_o), .write_o(write_o), .address_o(address_o),
      .write_data_o(write_data_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
      .first_err_o(first_err_o), .timeout_o(timeout_o)
   );

   dram_traffic_gen #(.ADDR_BASE(27'h7FF_FFF0), .NUM_XFERS(4)) dut_wrap (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .busy_i(busy_i), .ack_i(ack2),
      .read_data_i(read_data2), .read_o(read2), .write_o(write2), .address_o(address2),
      .write_data_o(write_data2), .done_o(done2), .pass_o(pass2), .err_cnt_o(err_cnt2),
      .first_err_o(first_err2), .timeout_o(timeout2)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // sel: 0 = write_o, 1 = read_o, 2 = done_o
   task automatic wait_sig(input string tag, input int sel, input logic lvl, input int max_cyc);
      int   n = 0;
      logic v;
      forever begin
         v = (sel == 0) ? write_o : (sel == 1) ? read_o : done_o;
         if (v === lvl || n >= max_cyc) break;
         @(negedge clk_i);
         n++;
      end
      check_val(tag, 64'(v), 64'(lvl));
   endtask

   task automatic pulse_start();
      @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   // Main responder: acks on the third cycle a request is seen, backed by a memory model
   initial begin
      ack_i = 1'b0;
      read_data_i = 64'h0;
      forever begin
         @(negedge clk_i);
         ack_i = 1'b0;
         if (read_o && write_o) both_high++;
         if (write_o || read_o) begin
            req_cyc++;
            if (!no_ack && req_cyc == 3) begin
               ack_i = 1'b1;
               if (write_o) begin
                  mem[address_o] = write_data_o;
                  wr_q.push_back(address_o);
               end else begin
                  read_data_i = (mem.exists(address_o) ? mem[address_o] : 64'h0) ^
                                ((corrupt && address_o == 27'd40) ? 64'h20 : 64'h0);
                  rd_q.push_back(address_o);
               end
            end
         end else begin
            req_cyc = 0;
         end
      end
   end

   // Zero-wait responder: acks in the first cycle of every request
   initial begin
      ack2 = 1'b0;
      read_data2 = 64'h0;
      forever begin
         @(negedge clk_i);
         ack2 = 1'b0;
         if (write2) begin
            ack2 = 1'b1;
            mem2[address2] = write_data2;
            wr2_q.push_back(address2);
         end else if (read2) begin
            ack2 = 1'b1;
            read_data2 = mem2.exists(address2) ? mem2[address2] : 64'h0;
            rd2_q.push_back(address2);
         end else begin
            ack2 = 1'b0;
         end
      end
   end

   initial begin
      int          bad;
      int          cnt;
      logic [26:0] exp_wrap [4];
      exp_wrap = '{27'h7FF_FFF0, 27'h7FF_FFF8, 27'h000_0000, 27'h000_0008};
      start_i = 1'b0;
      busy_i  = 1'b1;
      #2 rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      check_val("rst_write", 64'(write_o), 64'd0);
      check_val("rst_read", 64'(read_o), 64'd0);
      check_val("rst_done", 64'(done_o), 64'd0);
      check_val("rst_addr", 64'(address_o), 64'd0);
      rst_ni = 1'b1;

      // busy held for 200 cycles with a start issued inside
      pulse_start();
      bad = 0;
      for (int i = 0; i < 198; i++) begin
         @(negedge clk_i);
         if (write_o || read_o) bad++;
      end
      check_val("no_req_while_busy", 64'(bad), 64'd0);
      busy_i = 1'b0;
      @(negedge clk_i);
      check_val("first_write_latency", 64'(write_o), 64'd1);
      check_val("first_write_addr", 64'(address_o), 64'd0);
      check_val("first_write_data", write_data_o, 64'h32D6_79B8_ACE1_0001);
      wait_sig("wr0_drop", 0, 1'b0, 20);
      check_val("gap_no_req", 64'(write_o | read_o), 64'd0);
      wait_sig("wr1_rise", 0, 1'b1, 20);
      check_val("second_write_addr", 64'(address_o), 64'd8);
      check_val("second_write_data", write_data_o, 64'h4867_F9BA_D650_8003);
      wait_sig("run1_done", 2, 1'b1, 3000);
      check_val("run1_pass", 64'(pass_o), 64'd1);
      check_val("run1_err_cnt", 64'(err_cnt_o), 64'd0);
      check_val("run1_first_err", 64'(first_err_o), 64'd0);
      check_val("run1_timeout", 64'(timeout_o), 64'd0);
      check_val("run1_wr_count", 64'(wr_q.size()), 64'd16);
      check_val("run1_rd_count", 64'(rd_q.size()), 64'd16);
      bad = 0;
      for (int k = 0; k < wr_q.size() && k < rd_q.size(); k++) begin
         if (wr_q[k] != 27'(k * 8) || rd_q[k] != 27'(k * 8)) bad++;
      end
      check_val("run1_addr_seq", 64'(bad), 64'd0);
      check_val("wrap_done", 64'(done2), 64'd1);
      check_val("wrap_pass", 64'(pass2), 64'd1);
      check_val("wrap_wr_count", 64'(wr2_q.size()), 64'd4);
      check_val("wrap_rd_count", 64'(rd2_q.size()), 64'd4);
      bad = 0;
      for (int k = 0; k < 4 && k < wr2_q.size() && k < rd2_q.size(); k++) begin
         if (wr2_q[k] != exp_wrap[k] || rd2_q[k] != exp_wrap[k]) bad++;
      end
      check_val("wrap_addr_seq", 64'(bad), 64'd0);

      // bit 5 flipped on the read of address 40
      corrupt = 1'b1;
      pulse_start();
      check_val("restart_clears_done", 64'(done_o), 64'd0);
      wait_sig("run2_done", 2, 1'b1, 3000);
      check_val("run2_err_cnt", 64'(err_cnt_o), 64'd1);
      check_val("run2_first_err", 64'(first_err_o), 64'd40);
      check_val("run2_pass", 64'(pass_o), 64'd0);
      corrupt = 1'b0;

      // responder never acks
      no_ack = 1'b1;
      pulse_start();
      wait_sig("run3_write_rise", 0, 1'b1, 50);
      cnt = 0;
      while (write_o && cnt < 5000) begin
         if (cnt == 4095) check_val("no_early_timeout", 64'(timeout_o), 64'd0);
         cnt++;
         @(negedge clk_i);
      end
      check_val("timeout_req_cycles", 64'(cnt), 64'd4096);
      check_val("timeout_flag", 64'(timeout_o), 64'd1);
      check_val("timeout_done", 64'(done_o), 64'd1);
      check_val("timeout_pass", 64'(pass_o), 64'd0);
      check_val("timeout_write_low", 64'(write_o), 64'd0);
      no_ack = 1'b0;

      // reset in the middle of the read phase, then a clean rerun
      pulse_start();
      wait_sig("run4_read_rise", 1, 1'b1, 3000);
      #2 rst_ni = 1'b0;
      #1;
      check_val("midrst_read", 64'(read_o), 64'd0);
      check_val("midrst_done", 64'(done_o), 64'd0);
      check_val("midrst_addr", 64'(address_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      wr_q.delete();
      rd_q.delete();
      pulse_start();
      wait_sig("run5_done", 2, 1'b1, 3000);
      check_val("run5_pass", 64'(pass_o), 64'd1);
      check_val("run5_err_cnt", 64'(err_cnt_o), 64'd0);
      check_val("run5_rd_count", 64'(rd_q.size()), 64'd16);
      check_val("never_both_req", 64'(both_high), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
